// File: rtl/vco_pkg.sv
// Shared constants, window FSM state type and ring-tap decode helpers
// for the VCO phase counter.
package vco_pkg;

  localparam int VCO_TAPS   = 11;
  localparam int NUM_STATES = 2 * VCO_TAPS;
  localparam int MAX_TAPS   = 32;

  typedef enum logic [1:0] {
    WIN_IDLE  = 2'd0,
    WIN_PRIME = 2'd1,
    WIN_ACC   = 2'd2
  } vco_win_state_t;

  // Odd taps of the ring are inverted; this mask folds them back to a thermometer.
  function automatic logic [MAX_TAPS-1:0] vco_alt_mask(input int n);
    return 32'hAAAA_AAAA & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic [6:0] vco_phase_decode(input logic [MAX_TAPS-1:0] taps,
                                                  input int n);
    logic [MAX_TAPS-1:0] t;
    logic [MAX_TAPS-1:0] walk;
    logic [MAX_TAPS-1:0] msb_sh;
    logic [6:0]          pc;
    t      = taps ^ vco_alt_mask(n);
    walk   = t;
    pc     = 7'd0;
    for (int i = 0; i < MAX_TAPS; i++) begin
      pc   = pc + {6'd0, walk[0]};
      walk = walk >> 1;
    end
    msb_sh = t >> (n - 1);
    if (msb_sh[0]) begin
      return 7'(2 * n) - pc;
    end else begin
      return pc;
    end
  endfunction

endpackage

// File: rtl/vco_sample_fifo.sv
// First-word fall-through sample buffer with occupancy level and a drop
// strobe for pushes that arrive while full with no concurrent pop.
module vco_sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             pop_s;
  logic             push_ok_s;

  assign full      = (level_r == LW'(DEPTH));
  assign empty     = (level_r == {LW{1'b0}});
  assign pop_s     = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok_s = push && (!full || pop_s);
  assign drop      = push && full && !pop_s;
  assign head      = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_r + LW'(push_ok_s) - LW'(pop_s);
    end
  end

endmodule

// File: rtl/vco_phase_counter.sv
// Converts asynchronous ring-oscillator taps into decimated frequency samples:
// synchronize, decode to a phase index, accumulate phase advance per window.
module vco_phase_counter
  import vco_pkg::*;
#(
  parameter int PHASE_WIDTH  = VCO_TAPS,
  parameter int SAMPLE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic [15:0]                   dec_len_i,
  input  logic [PHASE_WIDTH-1:0]        phase_in,
  output logic [SAMPLE_WIDTH-1:0]       sample_o,
  output logic                          sample_valid_o,
  input  logic                          sample_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          clear_overflow_i
);

  localparam int N_STATES = 2 * PHASE_WIDTH;
  localparam int PIDX_W   = $clog2(N_STATES);
  localparam logic [PIDX_W:0] N_STATES_W = (PIDX_W + 1)'(N_STATES);

  logic [PHASE_WIDTH-1:0]  s1_r, s2_r;
  logic [PIDX_W-1:0]       p_s, p_q_r, p_prev_r, delta_s;
  logic [PIDX_W:0]         diff_s;
  vco_win_state_t          state_r, state_nxt_s;
  logic [15:0]             len_r, cnt_r, len_sel_s;
  logic [SAMPLE_WIDTH-1:0] acc_r, acc_sat_s;
  logic [SAMPLE_WIDTH:0]   acc_sum_s;
  logic                    last_s, push_s, pop_s, drop_s, full_s, empty_s;
  logic                    overflow_r;

  assign p_s       = PIDX_W'(vco_phase_decode(MAX_TAPS'(s2_r), PHASE_WIDTH));
  assign diff_s    = {1'b0, p_q_r} - {1'b0, p_prev_r};
  // A backwards step in index means the ring wrapped through state 0.
  assign delta_s   = (p_q_r >= p_prev_r) ? diff_s[PIDX_W-1:0]
                                         : PIDX_W'(diff_s + N_STATES_W);
  assign acc_sum_s = {1'b0, acc_r} + (SAMPLE_WIDTH + 1)'(delta_s);
  assign acc_sat_s = acc_sum_s[SAMPLE_WIDTH] ? {SAMPLE_WIDTH{1'b1}}
                                             : acc_sum_s[SAMPLE_WIDTH-1:0];
  assign len_sel_s = (dec_len_i == 16'd0) ? 16'd1 : dec_len_i;
  assign last_s    = (cnt_r == len_r - 16'd1);
  assign pop_s     = sample_valid_o && sample_ready_i;

  // Window FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= WIN_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Window FSM next state and push strobe.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    case (state_r)
      WIN_IDLE: begin
        if (enable_i) state_nxt_s = WIN_PRIME;
        else          state_nxt_s = WIN_IDLE;
      end
      WIN_PRIME: begin
        if (enable_i) state_nxt_s = WIN_ACC;
        else          state_nxt_s = WIN_IDLE;
      end
      WIN_ACC: begin
        if (enable_i) begin
          state_nxt_s = WIN_ACC;
          push_s      = last_s;
        end else begin
          state_nxt_s = WIN_IDLE;
        end
      end
      default: state_nxt_s = WIN_IDLE;
    endcase
  end

  // Tap synchronizer, phase pipeline, window counter and accumulator.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1_r     <= {PHASE_WIDTH{1'b0}};
      s2_r     <= {PHASE_WIDTH{1'b0}};
      p_q_r    <= {PIDX_W{1'b0}};
      p_prev_r <= {PIDX_W{1'b0}};
      len_r    <= 16'd1;
      cnt_r    <= 16'd0;
      acc_r    <= {SAMPLE_WIDTH{1'b0}};
    end else begin
      s1_r  <= phase_in;
      s2_r  <= s1_r;
      p_q_r <= p_s;
      case (state_r)
        WIN_PRIME: begin
          p_prev_r <= p_q_r;
          len_r    <= len_sel_s;
          cnt_r    <= 16'd0;
          acc_r    <= {SAMPLE_WIDTH{1'b0}};
        end
        WIN_ACC: begin
          p_prev_r <= p_q_r;
          if (!enable_i || last_s) begin
            cnt_r <= 16'd0;
            acc_r <= {SAMPLE_WIDTH{1'b0}};
          end else begin
            cnt_r <= cnt_r + 16'd1;
            acc_r <= acc_sat_s;
          end
          if (last_s) begin
            len_r <= len_sel_s;
          end
        end
        default: begin
          cnt_r <= 16'd0;
          acc_r <= {SAMPLE_WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      overflow_r <= 1'b0;
    end else if (drop_s && full_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow_i) begin
      overflow_r <= 1'b0;
    end
  end

  vco_sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push_s),
    .push_data (acc_sat_s),
    .pop       (pop_s),
    .head      (sample_o),
    .level     (fifo_level_o),
    .full      (full_s),
    .empty     (empty_s),
    .drop      (drop_s)
  );

  assign sample_valid_o = !empty_s;
  assign overflow_o     = overflow_r;

endmodule

// File: tb/tb_vco_phase_counter.sv
// Directed bench for vco_phase_counter: ring taps are generated from a phase
// index, and sample values, window timing and FIFO behaviour are checked.
module tb_vco_phase_counter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [15:0] dec_len_i = 16'd4;
  logic [10:0] phase_in = 11'h2AA;
  logic [23:0] sample_o;
  logic        sample_valid_o;
  logic        sample_ready_i = 1'b0;
  logic [3:0]  fifo_level_o;
  logic        overflow_o;
  logic        clear_overflow_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int ph   = 0;
  int rate = 0;

  vco_phase_counter dut (
    .wb_clk_i         (wb_clk_i),
    .wb_rst_i         (wb_rst_i),
    .enable_i         (enable_i),
    .dec_len_i        (dec_len_i),
    .phase_in         (phase_in),
    .sample_o         (sample_o),
    .sample_valid_o   (sample_valid_o),
    .sample_ready_i   (sample_ready_i),
    .fifo_level_o     (fifo_level_o),
    .overflow_o       (overflow_o),
    .clear_overflow_i (clear_overflow_i)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  // Ring state k: thermometer of k ones (k<=11), then ones drain from the bottom.
  function automatic logic [10:0] enc(input int k);
    logic [10:0] t;
    if (k <= 11) t = 11'((32'd1 << k) - 32'd1);
    else         t = 11'h7FF & ~11'((32'd1 << (k - 11)) - 32'd1);
    return t ^ 11'h2AA;
  endfunction

  initial forever begin
    @(negedge wb_clk_i);
    ph = (ph + rate) % 22;
    phase_in = enc(ph);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic wait_valid(input int max, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge wb_clk_i);
      n++;
      if (sample_valid_o) ok = 1'b1;
    end
  endtask

  task automatic idle_drain();
    enable_i = 1'b0;
    sample_ready_i = 1'b1;
    clear_overflow_i = 1'b1;
    cycles(12);
    clear_overflow_i = 1'b0;
    sample_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    cycles(3);
    tests_run++;
    if (sample_o !== 24'd0) begin tests_failed++; $display("FAIL reset_sample: got %0d want 0", sample_o); end
    tests_run++;
    if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", sample_valid_o); end
    tests_run++;
    if (fifo_level_o !== 4'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    wb_rst_i = 1'b0;
    cycles(5);
  endtask

  task automatic test_frozen();
    int n;
    bit ok;
    rate = 0;
    dec_len_i = 16'd4;
    sample_ready_i = 1'b1;
    cycles(5);
    enable_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_valid(20, n, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL frozen_timeout[%0d]: no sample within %0d cycles", s, n); end
      tests_run++;
      if (sample_o !== 24'd0) begin tests_failed++; $display("FAIL frozen_value[%0d]: got %0d want 0", s, sample_o); end
      if (s > 0) begin
        tests_run++;
        if (n != 4) begin tests_failed++; $display("FAIL frozen_period[%0d]: got %0d want 4", s, n); end
      end
    end
    idle_drain();
  endtask

  task automatic test_rotation(input string name, input int r, input int len, input int expv);
    int n;
    bit ok;
    rate = r;
    dec_len_i = 16'(len);
    sample_ready_i = 1'b1;
    cycles(5);
    enable_i = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_valid(len + 10, n, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL %s_timeout[%0d]: no sample within %0d cycles", name, s, n); end
      tests_run++;
      if (sample_o !== 24'(expv)) begin tests_failed++; $display("FAIL %s_value[%0d]: got %0d want %0d", name, s, sample_o, expv); end
    end
    idle_drain();
  endtask

  task automatic test_len_zero();
    int n;
    rate = 1;
    dec_len_i = 16'd0;
    sample_ready_i = 1'b0;
    cycles(5);
    enable_i = 1'b1;
    n = 0;
    while (n < 20 && fifo_level_o == 4'd0) begin @(negedge wb_clk_i); n++; end
    tests_run++;
    if (fifo_level_o !== 4'd1) begin tests_failed++; $display("FAIL len0_first: level %0d want 1", fifo_level_o); end
    @(negedge wb_clk_i);
    tests_run++;
    if (fifo_level_o !== 4'd2) begin tests_failed++; $display("FAIL len0_every_clock: level %0d want 2", fifo_level_o); end
    tests_run++;
    if (sample_o !== 24'd1) begin tests_failed++; $display("FAIL len0_value: got %0d want 1", sample_o); end
    idle_drain();
  endtask

  task automatic test_backpressure();
    int n;
    bit seen;
    logic [3:0] prev;
    rate = 1;
    dec_len_i = 16'd3;
    sample_ready_i = 1'b0;
    cycles(5);
    enable_i = 1'b1;
    cycles(2);
    dec_len_i = 16'd4;
    for (int k = 0; k < 9; k++) begin
      prev = fifo_level_o;
      n = 0;
      seen = 1'b0;
      while (n < 30 && !seen) begin
        @(negedge wb_clk_i);
        n++;
        if (fifo_level_o != prev || overflow_o) seen = 1'b1;
      end
      tests_run++;
      if (!seen) begin tests_failed++; $display("FAIL bp_push_timeout[%0d]: level %0d", k, fifo_level_o); end
      dec_len_i = 16'(3 + k + 2);
    end
    enable_i = 1'b0;
    tests_run++;
    if (fifo_level_o !== 4'd8) begin tests_failed++; $display("FAIL bp_level: got %0d want 8", fifo_level_o); end
    tests_run++;
    if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL bp_overflow: got %b want 1", overflow_o); end
    clear_overflow_i = 1'b1;
    @(negedge wb_clk_i);
    clear_overflow_i = 1'b0;
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL bp_clear: got %b want 0", overflow_o); end
    sample_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (sample_o !== 24'(3 + i) || sample_valid_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: got %0d valid %b want %0d valid 1", i, sample_o, sample_valid_o, 3 + i);
      end
      @(negedge wb_clk_i);
    end
    tests_run++;
    if (fifo_level_o !== 4'd0) begin tests_failed++; $display("FAIL bp_drained_level: got %0d want 0", fifo_level_o); end
    idle_drain();
  endtask

  task automatic test_full_fifo();
    int n;
    rate = 1;
    dec_len_i = 16'd4;
    sample_ready_i = 1'b0;
    cycles(5);
    enable_i = 1'b1;
    n = 0;
    while (n < 60 && fifo_level_o != 4'd8) begin @(negedge wb_clk_i); n++; end
    tests_run++;
    if (fifo_level_o !== 4'd8) begin tests_failed++; $display("FAIL full_fill: level %0d want 8", fifo_level_o); end
    cycles(3);
    sample_ready_i = 1'b1;
    @(negedge wb_clk_i);
    sample_ready_i = 1'b0;
    tests_run++;
    if (fifo_level_o !== 4'd8) begin tests_failed++; $display("FAIL full_pushpop_level: got %0d want 8", fifo_level_o); end
    tests_run++;
    if (overflow_o !== 1'b0) begin tests_failed++; $display("FAIL full_pushpop_overflow: got %b want 0", overflow_o); end
    cycles(4);
    tests_run++;
    if (overflow_o !== 1'b1) begin tests_failed++; $display("FAIL full_drop_overflow: got %b want 1", overflow_o); end
    idle_drain();
  endtask

  task automatic test_interrupt();
    int n;
    bit ok;
    rate = 1;
    dec_len_i = 16'd10;
    sample_ready_i = 1'b1;
    cycles(5);
    enable_i = 1'b1;
    cycles(7);
    enable_i = 1'b0;
    wait_valid(20, n, ok);
    tests_run++;
    if (ok) begin tests_failed++; $display("FAIL intr_no_push: got valid after %0d cycles want none", n); end
    enable_i = 1'b1;
    wait_valid(30, n, ok);
    tests_run++;
    if (!ok || n != 12) begin tests_failed++; $display("FAIL intr_first_push: got %0d cycles (seen %b) want 12", n, ok); end
    tests_run++;
    if (sample_o !== 24'd10) begin tests_failed++; $display("FAIL intr_value: got %0d want 10", sample_o); end
    sample_ready_i = 1'b0;
    cycles(15);
    tests_run++;
    if (fifo_level_o !== 4'd2) begin tests_failed++; $display("FAIL intr_prefill: level %0d want 2", fifo_level_o); end
    wb_rst_i = 1'b1;
    #1;
    tests_run++;
    if (sample_o !== 24'd0 || sample_valid_o !== 1'b0 || fifo_level_o !== 4'd0 || overflow_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL intr_async_reset: sample %0d valid %b level %0d ovf %b want all 0",
               sample_o, sample_valid_o, fifo_level_o, overflow_o);
    end
    enable_i = 1'b0;
    cycles(2);
    wb_rst_i = 1'b0;
    cycles(15);
    tests_run++;
    if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL intr_post_reset: valid %b want 0", sample_valid_o); end
  endtask

  initial begin
    test_reset();
    test_frozen();
    test_rotation("rot1", 1, 10, 10);
    test_rotation("rot3", 3, 10, 30);
    test_rotation("wrap", 1, 25, 25);
    test_len_zero();
    test_backpressure();
    test_full_fifo();
    test_interrupt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
